// File: rtl/encoder_pkg.sv
// Shared widths and types for the 8-to-3 request encoder.
package encoder_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  typedef logic [ENC_IN_W-1:0]  enc_req_t;
  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

endpackage : encoder_pkg

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder.
// HIGH_PRIO=1 picks the most significant set bit, 0 the least significant.
// any_o flags a non-zero request; multi_o flags more than one bit set.
module prio_enc8
  import encoder_pkg::*;
#(
  parameter bit HIGH_PRIO = 1'b1
) (
  input  enc_req_t d_i,
  output enc_idx_t idx_o,
  output logic     any_o,
  output logic     multi_o
);

  // Scan in the order that lets the winning bit be the last one written.
  always_comb begin
    idx_o = '0;
    if (HIGH_PRIO) begin
      for (int i = 0; i < ENC_IN_W; i++)
        if (d_i[i]) idx_o = enc_idx_t'(i);
    end else begin
      for (int i = ENC_IN_W - 1; i >= 0; i--)
        if (d_i[i]) idx_o = enc_idx_t'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if another bit was set.
  always_comb begin
    any_o   = |d_i;
    multi_o = |(d_i & (d_i - enc_req_t'(1)));
  end

endmodule : prio_enc8

// File: rtl/encoder_8to3.sv
// 8-to-3 encoder with registered index/valid, 1-cycle latency.
// Optional ENCODER_8TO3_ONEHOT_ERR_EN adds a registered multi-hot error flag.
module encoder_8to3
  import encoder_pkg::*;
#(
  parameter bit       HIGH_PRIO = 1'b1,
  parameter enc_idx_t RST_Y     = 3'd0
) (
  input  logic     clk,
  input  logic     rst,
  input  enc_req_t d,
  input  logic     enable,
  output enc_idx_t y,
  output logic     valid
`ifdef ENCODER_8TO3_ONEHOT_ERR_EN
  ,
  output logic     err
`endif
);

  enc_idx_t idx;
  logic     any;
  logic     multi;

  enc_idx_t y_q, y_d;
  logic     valid_q, valid_d;

  prio_enc8 #(.HIGH_PRIO(HIGH_PRIO)) u_prio (
    .d_i     (d),
    .idx_o   (idx),
    .any_o   (any),
    .multi_o (multi)
  );

  // Enable gates first so an undriven d while disabled never reaches y.
  always_comb begin
    y_d     = RST_Y;
    valid_d = 1'b0;
    if (enable == 1'b1 && any == 1'b1) begin
      y_d     = idx;
      valid_d = 1'b1;
    end
  end

  // Output registers; reset forces the idle encoding asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= RST_Y;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;

`ifdef ENCODER_8TO3_ONEHOT_ERR_EN
  logic err_q, err_d;

  // Multi-hot is only an error while the encoder is enabled.
  always_comb begin
    err_d = 1'b0;
    if (enable == 1'b1) err_d = multi;
  end

  // Error flag register, aligned with y/valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic multi_unused;
  assign multi_unused = multi;
`endif

endmodule : encoder_8to3

// File: tb/tb_encoder_8to3.sv
// Self-checking bench for encoder_8to3: one DUT per priority mode, shared inputs.
module tb_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       enable;
  logic [2:0] y_hi, y_lo;
  logic       v_hi, v_lo;
  logic       e_hi, e_lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  encoder_8to3 #(.HIGH_PRIO(1'b1), .RST_Y(3'd0)) dut_hi (
    .clk(clk), .rst(rst), .d(d), .enable(enable), .y(y_hi), .valid(v_hi)
`ifdef ENCODER_8TO3_ONEHOT_ERR_EN
    , .err(e_hi)
`endif
  );

  encoder_8to3 #(.HIGH_PRIO(1'b0), .RST_Y(3'd0)) dut_lo (
    .clk(clk), .rst(rst), .d(d), .enable(enable), .y(y_lo), .valid(v_lo)
`ifdef ENCODER_8TO3_ONEHOT_ERR_EN
    , .err(e_lo)
`endif
  );

`ifndef ENCODER_8TO3_ONEHOT_ERR_EN
  assign e_hi = 1'b0;
  assign e_lo = 1'b0;
`endif

  // Reference: index by repeated halving, bit count by remainders.
  function automatic void model(input logic en, input logic [7:0] dv, input bit hp,
                                output logic [2:0] ey, output logic ev, output logic ee);
    int v, idx, pop;
    ey = 3'd0; ev = 1'b0; ee = 1'b0;
    if (en !== 1'b1) return;
    v = int'(dv);
    if (v == 0) return;
    pop = 0;
    for (int t = v; t > 0; t = t / 2) pop += t % 2;
    idx = 0;
    if (hp) begin
      while (v > 1) begin v = v / 2; idx++; end
    end else begin
      while (v % 2 == 0) begin v = v / 2; idx++; end
    end
    ey = 3'(idx);
    ev = 1'b1;
    ee = (pop > 1);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d = 8'h10; enable = 1'b1;
    #2;
    checks++;
    if (y_hi !== 3'd0 || v_hi !== 1'b0) begin
      errors++; $display("FAIL reset_async: y=%0d valid=%b want y=0 valid=0", y_hi, v_hi);
    end
    tick();
    checks++;
    if (y_hi !== 3'd0 || v_hi !== 1'b0 || e_hi !== 1'b0) begin
      errors++; $display("FAIL reset_hold: y=%0d valid=%b err=%b want 0/0/0", y_hi, v_hi, e_hi);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (y_hi !== 3'd4 || v_hi !== 1'b1 || y_lo !== 3'd4) begin
      errors++; $display("FAIL reset_release: y_hi=%0d y_lo=%0d valid=%b want 4/4/1", y_hi, y_lo, v_hi);
    end
    // Mid-stream reset must clear outputs with no clock edge.
    d = 8'h80;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (y_hi !== 3'd0 || v_hi !== 1'b0) begin
      errors++; $display("FAIL reset_midstream: y=%0d valid=%b want y=0 valid=0", y_hi, v_hi);
    end
    d = 8'h04;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (y_hi !== 3'd2 || v_hi !== 1'b1) begin
      errors++; $display("FAIL reset_rerelease: y=%0d valid=%b want y=2 valid=1", y_hi, v_hi);
    end
  endtask

  task automatic test_sweep();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 8'(1 << i);
      tick();
      checks++;
      if (y_hi !== 3'(i) || v_hi !== 1'b1 || y_lo !== 3'(i) || v_lo !== 1'b1 || e_hi !== 1'b0) begin
        errors++;
        $display("FAIL sweep[%0d]: y_hi=%0d y_lo=%0d v=%b%b err=%b want y=%0d valid=1 err=0",
                 i, y_hi, y_lo, v_hi, v_lo, e_hi, i);
      end
    end
  endtask

  task automatic test_idle();
    enable = 1'b1; d = 8'h00;
    tick();
    checks++;
    if (y_hi !== 3'd0 || v_hi !== 1'b0) begin
      errors++; $display("FAIL idle_zero: y=%0d valid=%b want 0/0", y_hi, v_hi);
    end
    enable = 1'b0; d = 8'h40;
    tick();
    checks++;
    if (y_hi !== 3'd0 || v_hi !== 1'b0 || y_lo !== 3'd0 || v_lo !== 1'b0) begin
      errors++; $display("FAIL idle_disable: y=%0d valid=%b want 0/0", y_hi, v_hi);
    end
    d = 8'bxxxx_xxxx;
    tick();
    checks++;
    if (y_hi !== 3'd0 || v_hi !== 1'b0 || y_lo !== 3'd0 || v_lo !== 1'b0 || e_hi !== 1'b0) begin
      errors++; $display("FAIL idle_xblock: y=%b valid=%b err=%b want 000/0/0", y_hi, v_hi, e_hi);
    end
    enable = 1'b1; d = 8'h40;
    tick();
    checks++;
    if (y_hi !== 3'd6 || v_hi !== 1'b1) begin
      errors++; $display("FAIL idle_reenable: y=%0d valid=%b want 6/1", y_hi, v_hi);
    end
  endtask

  task automatic test_multihot();
    enable = 1'b1; d = 8'hFF;
    tick();
    checks++;
    if (y_hi !== 3'd7 || y_lo !== 3'd0 || v_hi !== 1'b1 || v_lo !== 1'b1) begin
      errors++; $display("FAIL multi_ff: y_hi=%0d y_lo=%0d v=%b%b want 7/0/11", y_hi, y_lo, v_hi, v_lo);
    end
`ifdef ENCODER_8TO3_ONEHOT_ERR_EN
    checks++;
    if (e_hi !== 1'b1 || e_lo !== 1'b1) begin
      errors++; $display("FAIL err_ff: err=%b%b want 11", e_hi, e_lo);
    end
`endif
    d = 8'b0010_0110;
    tick();
    checks++;
    if (y_hi !== 3'd5 || y_lo !== 3'd1 || v_hi !== 1'b1 || v_lo !== 1'b1) begin
      errors++; $display("FAIL multi_26: y_hi=%0d y_lo=%0d v=%b%b want 5/1/11", y_hi, y_lo, v_hi, v_lo);
    end
    d = 8'h08;
    tick();
    checks++;
    if (y_hi !== 3'd3 || e_hi !== 1'b0) begin
      errors++; $display("FAIL err_onehot: y=%0d err=%b want 3/0", y_hi, e_hi);
    end
    enable = 1'b0; d = 8'hFF;
    tick();
    checks++;
    if (e_hi !== 1'b0 || v_hi !== 1'b0) begin
      errors++; $display("FAIL err_disabled: err=%b valid=%b want 0/0", e_hi, v_hi);
    end
  endtask

  task automatic test_random();
    logic [2:0] eyh, eyl;
    logic       evh, evl, eeh, eel;
    for (int n = 0; n < 300; n++) begin
      enable = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0:       d = 8'(1 << $urandom_range(7));
        1:       d = 8'h00;
        default: d = 8'($urandom);
      endcase
      if (!enable && $urandom_range(4) == 0) d = 8'bxxxx_xxxx;
      model(enable, d, 1'b1, eyh, evh, eeh);
      model(enable, d, 1'b0, eyl, evl, eel);
`ifndef ENCODER_8TO3_ONEHOT_ERR_EN
      eeh = 1'b0; eel = 1'b0;
`endif
      tick();
      checks++;
      if (y_hi !== eyh || v_hi !== evh || y_lo !== eyl || v_lo !== evl || e_hi !== eeh || e_lo !== eel) begin
        errors++;
        $display("FAIL random[%0d]: got hi=%0d/%b/%b lo=%0d/%b/%b want hi=%0d/%b/%b lo=%0d/%b/%b",
                 n, y_hi, v_hi, e_hi, y_lo, v_lo, e_lo, eyh, evh, eeh, eyl, evl, eel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_idle();
    test_multihot();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_encoder_8to3
